tree_output_accumulator: RTL and testbench
==========================================

// Module: tree_output_accumulator
// PURPOSE
//  Consumer end of the adder tree: takes root sums from NUM_LANES parallel trees and
//  accumulates len_i consecutive beats per lane into wide results. Emits one result
//  vector per group over a valid/ready handshake, so K-step dot products need no
//  wider tree. Sits between the last adder_tree_layer and the output buffer.
// PARAMETERS
//  NUM_LANES   4   parallel tree roots accumulated independently
//  IN_W        10  width of each tree-root sum (two's complement when signed)
//  MAX_LEN     16  max beats per group; LEN_W = $clog2(MAX_LEN+1)
//  ACC_W       IN_W+$clog2(MAX_LEN)  accumulator/result width (derived)
// PORTS
//  clk_i          in   1              clock, all state on rising edge
//  rst_i          in   1              async reset, active-high
//  in_valid_i     in   1              beat valid
//  in_ready_o     out  1              beat accepted when valid&&ready
//  data_i         in   IN_W x LANES   tree-root sums, one per lane
//  sign_unsign_ni in   1              1: sign-extend inputs, 0: zero-extend
//  len_i          in   LEN_W          beats in group; sampled on first beat only
//  out_valid_o    out  1              result vector valid
//  out_ready_i    in   1              result consumed when valid&&ready
//  data_o         out  ACC_W x LANES  accumulated results
//  busy_o         out  1              group in progress or result pending
// BEHAVIOUR
//  Reset (async, any cycle): state=IDLE, accs=0, count=0, in_ready_o=1,
//   out_valid_o=0, data_o=0, busy_o=0. Mid-group reset discards partial sums.
//  FSM IDLE -> ACCUM -> OUTPUT -> IDLE.
//  IDLE: in_ready_o=1. On handshake: latch len (0 treated as 1, >MAX_LEN clamped
//   to MAX_LEN), latch sign mode, acc[l]=ext(data_i[l]), count=1;
//   if len==1 go OUTPUT else ACCUM.
//  ACCUM: in_ready_o=1; sign_unsign_ni/len_i ignored (latched values used).
//   On handshake acc[l]+=ext(data_i[l]), count++; when count reaches len go OUTPUT.
//   No handshake: state held, no change.
//  OUTPUT: in_ready_o=0, out_valid_o=1, data_o=acc stable until out_ready_i.
//   On out handshake: out_valid_o=0 next cycle, go IDLE. No same-cycle bypass:
//   a new group's first beat is accepted one cycle after the output handshake.
//  Latency: result visible the cycle after the len-th input beat is accepted.
//  ext(): IN_W->ACC_W, sign or zero extension per latched mode.
//  Add is ACC_W modular (wrap); ACC_W chosen so MAX_LEN beats never overflow.
//  out_valid_o never drops without handshake; data_o never changes while valid.
//  busy_o = (state != IDLE).
// STRUCTURE
//  adder_tree_pkg: acc_state_e {IDLE,ACCUM,OUTPUT}; helper function
//   ext_operand(width, signed) shared with the tree layers.
//  Sub-module acc_lane (one per lane, generate loop): extender + existing adder
//   (DATAW=ACC_W) + acc register with load/add enables; FSM and counter in top.
// TESTING
//  Signed, len=4, lane0 inputs -1,-2,3,5 (IN_W=10) -> data_o[0]=5 after 4 beats.
//  Unsigned, len=4, all lanes 10'h3FF -> each lane 4092, no wrap, ACC_W=14.
//  len=1 -> out_valid_o next cycle equals ext(data_i); len=0 behaves as len=1.
//  out_ready_i low 5 cycles -> in_ready_o=0, data_o stable; then one-cycle IDLE.
//  Sign/len toggled mid-group -> ignored; result uses values from first beat.
//  rst_i asserted after beat 2 of 4 -> all outputs 0 immediately; next group clean.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared widths, accumulator states and operand extension for the adder tree
package adder_tree_pkg;

  localparam int NUM_LANES = 4;
  localparam int IN_W      = 10;
  localparam int MAX_LEN   = 16;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);
  localparam int ACC_W     = IN_W + $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } acc_state_e;

  // val holds a width-bit operand in its low bits; the upper bits are rebuilt from the mode
  function automatic logic [ACC_W-1:0] ext_operand(input logic [ACC_W-1:0] val,
                                                   input int               width,
                                                   input logic             is_signed);
    logic [ACC_W-1:0] r;
    logic             fill;
    fill = is_signed & val[width-1];
    for (int i = 0; i < ACC_W; i++) begin
      r[i] = (i < width) ? val[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/tree_output_accumulator_acc_lane.sv
// rtl/tree_output_accumulator_acc_lane.sv - one lane: operand extension, adder and accumulator register
module acc_lane
  import adder_tree_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             add_i,
  input  logic             is_signed_i,
  input  logic [IN_W-1:0]  din_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_q;

  assign operand = ext_operand({{(ACC_W-IN_W){1'b0}}, din_i}, IN_W, is_signed_i);
  assign sum     = acc_q + operand;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= operand;
    end else if (add_i) begin
      acc_q <= sum;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/tree_output_accumulator.sv
// rtl/tree_output_accumulator.sv - accumulates len beats of per-lane tree sums into wide results
module tree_output_accumulator
  import adder_tree_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [NUM_LANES*IN_W-1:0]  data_i,
  input  logic                       sign_unsign_ni,
  input  logic [LEN_W-1:0]           len_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [NUM_LANES*ACC_W-1:0] data_o,
  output logic                       busy_o
);

  acc_state_e       state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             sign_q, sign_d;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] count_inc;
  logic             in_fire;
  logic             load;
  logic             add;
  logic             lane_sign;

  always_comb begin
    len_eff = len_i;
    if (len_i == '0) begin
      len_eff = LEN_W'(1);
    end else if (len_i > LEN_W'(MAX_LEN)) begin
      len_eff = LEN_W'(MAX_LEN);
    end
  end

  assign in_ready_o  = (state_q != OUTPUT);
  assign out_valid_o = (state_q == OUTPUT);
  assign busy_o      = (state_q != IDLE);
  assign in_fire     = in_valid_i && in_ready_o;
  assign load        = in_fire && (state_q == IDLE);
  assign add         = in_fire && (state_q == ACCUM);
  assign count_inc   = count_q + LEN_W'(1);
  // First beat uses the live mode; later beats use the mode latched with it
  assign lane_sign   = (state_q == IDLE) ? sign_unsign_ni : sign_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    sign_d  = sign_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          len_d   = len_eff;
          sign_d  = sign_unsign_ni;
          count_d = LEN_W'(1);
          state_d = (len_eff == LEN_W'(1)) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    acc_lane u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load),
      .add_i       (add),
      .is_signed_i (lane_sign),
      .din_i       (data_i[l*IN_W +: IN_W]),
      .acc_o       (data_o[l*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_tree_output_accumulator.sv
// tb/tb_tree_output_accumulator.sv - table-driven scoreboard bench for tree_output_accumulator
module tb_tree_output_accumulator;

  localparam int LANES = 4;
  localparam int IW    = 10;
  localparam int AW    = 14;
  localparam int LW    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LANES*IW-1:0] data_in = '0;
  logic              sign_in = 1'b0;
  logic [LW-1:0]     len_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LANES*AW-1:0] data_out;
  logic              busy;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  logic [LANES*AW-1:0] sb_q[$];

  typedef struct packed {
    logic              sign;
    logic [LW-1:0]     len;
    logic              toggle;
    logic [2:0]        hold;
    logic              has_exp;
    logic [AW-1:0]     exp0;
    logic [15:0][LANES*IW-1:0] beats;
  } vec_t;

  vec_t tbl[8];

  tree_output_accumulator dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .data_i         (data_in),
    .sign_unsign_ni (sign_in),
    .len_i          (len_in),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .data_o         (data_out),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ext_m(input logic [IW-1:0] v, input logic s);
    if (s) return {{(AW-IW){v[IW-1]}}, v};
    else   return {{(AW-IW){1'b0}}, v};
  endfunction

  // Output side of the scoreboard: pop on each output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'd0);
      end else begin
        check("sb_result", 64'(data_out), 64'(sb_q.pop_front()));
      end
    end
  end

  task automatic drive_beat(input vec_t v, input int b);
    int guard;
    in_valid = 1'b1;
    data_in  = v.beats[b];
    sign_in  = (b > 0 && v.toggle) ? ~v.sign : v.sign;
    len_in   = (b > 0 && v.toggle) ? LW'($urandom_range(1, 31)) : v.len;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_group(input vec_t v, input string tag);
    int eff;
    logic [LANES*AW-1:0] expv;
    logic [AW-1:0] acc;
    eff = (v.len == 0) ? 1 : (v.len > 16) ? 16 : int'(v.len);
    for (int l = 0; l < LANES; l++) begin
      acc = '0;
      for (int b = 0; b < eff; b++) acc = acc + ext_m(v.beats[b][l*IW +: IW], v.sign);
      expv[l*AW +: AW] = acc;
    end
    sb_q.push_back(expv);
    for (int b = 0; b < eff; b++) begin
      drive_beat(v, b);
      if (b < eff - 1) check({tag, "_midvalid"}, 64'(out_valid), 64'd0);
    end
    check({tag, "_latency"}, 64'(out_valid), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    if (v.has_exp) check({tag, "_lane0"}, 64'(data_out[AW-1:0]), 64'(v.exp0));
    for (int h = 0; h < int'(v.hold); h++) begin
      in_valid = 1'b1;
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(data_out), 64'(expv));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic signed [IW-1:0] l0 [4];
    l0[0] = -10'sd1; l0[1] = -10'sd2; l0[2] = 10'sd3; l0[3] = 10'sd5;
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '0;
      for (int b = 0; b < 16; b++) tbl[i].beats[b] = {$urandom, $urandom};
    end
    tbl[0].sign = 1'b1; tbl[0].len = 5'd4; tbl[0].has_exp = 1'b1; tbl[0].exp0 = 14'd5;
    for (int b = 0; b < 4; b++) tbl[0].beats[b][IW-1:0] = l0[b];
    tbl[1].sign = 1'b0; tbl[1].len = 5'd4; tbl[1].hold = 3'd5; tbl[1].has_exp = 1'b1;
    tbl[1].exp0 = 14'd4092;
    for (int b = 0; b < 16; b++) tbl[1].beats[b] = '1;
    tbl[2].sign = 1'b1; tbl[2].len = 5'd1;
    tbl[3].sign = 1'b0; tbl[3].len = 5'd0; tbl[3].hold = 3'd1;
    tbl[4].sign = 1'b1; tbl[4].len = 5'd16; tbl[4].has_exp = 1'b1; tbl[4].exp0 = 14'h2000;
    for (int b = 0; b < 16; b++) tbl[4].beats[b] = {LANES{10'h200}};
    tbl[5].sign = 1'b0; tbl[5].len = 5'd20; tbl[5].has_exp = 1'b1; tbl[5].exp0 = 14'd16368;
    for (int b = 0; b < 16; b++) tbl[5].beats[b] = '1;
    tbl[6].sign = 1'b1; tbl[6].len = 5'd5; tbl[6].toggle = 1'b1; tbl[6].hold = 3'd2;
    tbl[7].sign = 1'b0; tbl[7].len = 5'd3; tbl[7].toggle = 1'b1;

    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_group(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a 4-beat group discards the partial sums
    drive_beat(tbl[1], 0);
    drive_beat(tbl[1], 1);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(data_out), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_group(tbl[0], "post_rst");

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
